// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   REQ_I / REQ_D : requester identifiers (fetch / data)
//   ADDR_W/DATA_W : default word-address and data widths
package cpu_pkg;

    parameter int ADDR_W = 30;
    parameter int DATA_W = 32;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the pipeline-side and memory-side signals of the arbiter.
//   Fetch : i_req, i_addr -> i_rdata, i_ready
//   Data  : d_read, d_write, d_addr, d_wdata -> d_rdata, d_ready
//   Memory: mem_read, mem_write, mem_addr, mem_wdata <- mem_rdata, mem_ready
// Modports:
//   slave  : the arbiter's view (drives ready/rdata and the mem_* strobes)
//   master : the environment's view (pipeline requesters plus memory model)
interface mem_arbiter_if
    import cpu_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// data access. The granted request is held on the mem_* outputs until
// mem_ready, read data is returned to the winner with a one-cycle ready
// pulse, and a dead RESP cycle follows every access before the next grant.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (aborts any access in flight)
//   bus  : mem_arbiter_if.slave, requester and memory signals
//
// Build option MEM_ARB_RR_EN: when defined, a last_d flag alternates the
// grant when both requesters are pending; otherwise data always wins.
//
// state  | meaning
// IDLE   | no access in flight, grant decided this cycle
// BUSY_I | fetch access on the memory port, waiting for mem_ready
// BUSY_D | data access on the memory port, waiting for mem_ready
// RESP   | winner's ready pulse; no grant is made in this cycle
module mem_arbiter
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t state;
    arb_state_t next_state;

    logic d_req;
    logic prefer_i;
    logic grant_valid;
    logic grant_id;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // Only a both-pending IDLE cycle consults last_d; a lone requester wins.
    assign prefer_i = last_d & bus.i_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (bus.mem_ready) begin
            if (state == BUSY_D) begin
                last_d <= 1'b1;
            end else if (state == BUSY_I) begin
                last_d <= 1'b0;
            end
        end
    end
`else
    assign prefer_i = 1'b0;
`endif

    // A simultaneous read+write is treated as a write.
    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_id    = REQ_D;
        case (state)
            IDLE: begin
                if (d_req && !prefer_i) begin
                    grant_valid = 1'b1;
                    grant_id    = REQ_D;
                    next_state  = BUSY_D;
                end else if (bus.i_req) begin
                    grant_valid = 1'b1;
                    grant_id    = REQ_I;
                    next_state  = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All outputs are registered; the memory port is loaded only at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        if (grant_id == REQ_D) begin
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_write <= bus.d_write;
                            bus.mem_read  <= ~bus.d_write;
                        end else begin
                            bus.mem_addr  <= bus.i_addr;
                            bus.mem_read  <= 1'b1;
                            bus.mem_write <= 1'b0;
                        end
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ready) begin
                        bus.mem_read <= 1'b0;
                        bus.i_rdata  <= bus.mem_rdata;
                        bus.i_ready  <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ready) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        // Stores leave the load-data register untouched.
                        if (!bus.mem_write) begin
                            bus.d_rdata <= bus.mem_rdata;
                        end
                        bus.d_ready <= 1'b1;
                    end
                end
                RESP: begin
                    bus.i_ready <= 1'b0;
                    bus.d_ready <= 1'b0;
                end
                default: begin
                    bus.i_ready <= 1'b0;
                    bus.d_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if #(.AW(ADDR_W), .DW(DATA_W)) bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first strobe cycle of an access; returns in the ready cycle.
    task automatic serve(input string tag, input bit exp_d, input logic [29:0] exp_addr,
                         input bit exp_wr, input logic [31:0] rdata);
        check({tag, "_rd"}, 32'(bus.mem_read), 32'(!exp_wr));
        check({tag, "_wr"}, 32'(bus.mem_write), 32'(exp_wr));
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        check({tag, "_strobe_off"}, 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check({tag, "_i_ready"}, 32'(bus.i_ready), 32'(!exp_d));
        check({tag, "_d_ready"}, 32'(bus.d_ready), 32'(exp_d));
        if (!exp_d) check({tag, "_i_rdata"}, bus.i_rdata, rdata);
        else if (!exp_wr) check({tag, "_d_rdata"}, bus.d_rdata, rdata);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        rst = 1'b1;
        #3;
        check("reset_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check("reset_readies", 32'({bus.i_ready, bus.d_ready}), 32'd0);
        check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("reset_i_rdata", bus.i_rdata, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Fetch with three-cycle memory; request held through its ready cycle.
        bus.i_req = 1; bus.i_addr = 30'h10;
        step();
        check("f1_c1_rd", 32'(bus.mem_read), 32'd1);
        check("f1_c1_addr", 32'(bus.mem_addr), 32'h10);
        step();
        check("f1_c2_rd", 32'(bus.mem_read), 32'd1);
        check("f1_c2_ready", 32'(bus.i_ready), 32'd0);
        step();
        serve("f1", 1'b0, 30'h10, 1'b0, 32'hDEADBEEF);
        step();
        check("f1_pulse_end", 32'(bus.i_ready), 32'd0);
        check("f1_rdata_hold", bus.i_rdata, 32'hDEADBEEF);
        bus.i_req = 0;
        step();
        check("f1_no_regrant", 32'(bus.mem_read), 32'd0);
        step();
        check("f1_no_regrant2", 32'(bus.mem_read), 32'd0);

        // Stray mem_ready while idle must be ignored.
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        check("idle_ready_ignored", 32'({bus.i_ready, bus.d_ready}), 32'd0);

        // Both requesters held continuously.
        bus.i_req = 1; bus.i_addr = 30'h100;
        bus.d_read = 1; bus.d_addr = 30'h200;
        step();
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) serve($sformatf("rr%0d_D", k), 1'b1, 30'h200, 1'b0, 32'hA000_0000 + k);
            else            serve($sformatf("rr%0d_I", k), 1'b0, 30'h100, 1'b0, 32'hB000_0000 + k);
            if (k == 5) begin
                bus.i_req = 0;
                bus.d_read = 0;
            end
            step();
            step();
        end
        check("rr_done_idle", 32'({bus.mem_read, bus.mem_write}), 32'd0);
`else
        for (int k = 0; k < 3; k++) begin
            serve($sformatf("fx%0d_D", k), 1'b1, 30'h200, 1'b0, 32'hA000_0000 + k);
            if (k == 2) bus.d_read = 0;
            step();
            step();
        end
        serve("fx_I", 1'b0, 30'h100, 1'b0, 32'hB000_0000);
        bus.i_req = 0;
        step();
        step();
        check("fx_done_idle", 32'({bus.mem_read, bus.mem_write}), 32'd0);
`endif

        // Zero-wait data write; d_rdata keeps its last load value.
        bus.d_write = 1; bus.d_addr = 30'h20; bus.d_wdata = 32'h12345678;
        step();
        check("w_wdata", bus.mem_wdata, 32'h12345678);
        serve("w", 1'b1, 30'h20, 1'b1, 32'hFFFF_FFFF);
`ifdef MEM_ARB_RR_EN
        check("w_d_rdata_kept", bus.d_rdata, 32'hA000_0004);
`else
        check("w_d_rdata_kept", bus.d_rdata, 32'hA000_0002);
`endif
        bus.d_write = 0;
        step();
        check("w_pulse_end", 32'(bus.d_ready), 32'd0);
        step();

        // Simultaneous requests; each winner drops its request after ready.
        bus.i_req = 1; bus.i_addr = 30'h30;
        bus.d_read = 1; bus.d_addr = 30'h40;
        step();
`ifdef MEM_ARB_RR_EN
        serve("sim_first_I", 1'b0, 30'h30, 1'b0, 32'h1111_0000);
        bus.i_req = 0;
        step();
        step();
        serve("sim_second_D", 1'b1, 30'h40, 1'b0, 32'h2222_0000);
        bus.d_read = 0;
`else
        serve("sim_first_D", 1'b1, 30'h40, 1'b0, 32'h2222_0000);
        bus.d_read = 0;
        step();
        step();
        serve("sim_second_I", 1'b0, 30'h30, 1'b0, 32'h1111_0000);
        bus.i_req = 0;
`endif
        step();
        step();
        check("sim_idle", 32'({bus.mem_read, bus.mem_write}), 32'd0);

        // Reset in the middle of a data write.
        bus.d_write = 1; bus.d_addr = 30'h77; bus.d_wdata = 32'hCAFE_F00D;
        step();
        check("abort_pre_wr", 32'(bus.mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_async_wr", 32'(bus.mem_write), 32'd0);
        check("abort_no_ready", 32'(bus.d_ready), 32'd0);
        bus.d_write = 0;
        step();
        rst = 1'b0;
        step();
        check("abort_after_ready", 32'({bus.i_ready, bus.d_ready}), 32'd0);
        bus.i_req = 1; bus.i_addr = 30'h55;
        step();
        serve("post_rst_I", 1'b0, 30'h55, 1'b0, 32'h5555_AAAA);
        bus.i_req = 0;
        step();
        check("post_rst_d_ready", 32'(bus.d_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between the pipeline's instruction-fetch (IF) and data-access (MEM) requesters. Sits between the five-stage pipeline and the memory model. Holds the granted request on the memory port until `mem_ready`, returns read data to the winner with a one-cycle ready pulse, and leaves the loser waiting. The pipeline's hazard logic stalls on any requester whose request is high while its ready is low.

## Interface
- `ADDR_W`, 30, word-address width
- `DATA_W`, 32, data width

- `clk` in 1 system clock, rising edge
- `rst` in 1 asynchronous, active-high reset
- `i_req` in 1 fetch request, held until `i_ready`
- `i_addr` in ADDR_W fetch address
- `i_rdata` out DATA_W fetch data, valid while `i_ready`
- `i_ready` out 1 one-cycle fetch-complete pulse
- `d_read` in 1 data read request, held until `d_ready`
- `d_write` in 1 data write request, held until `d_ready`
- `d_addr` in ADDR_W data address
- `d_wdata` in DATA_W store data
- `d_rdata` out DATA_W load data, valid while `d_ready`
- `d_ready` out 1 one-cycle data-complete pulse
- `mem_read` out 1 memory read strobe
- `mem_write` out 1 memory write strobe
- `mem_addr` out ADDR_W memory address
- `mem_wdata` out DATA_W memory write data
- `mem_rdata` in DATA_W memory read data, valid with `mem_ready`
- `mem_ready` in 1 memory access complete, single cycle

## Operation
- Every output is registered. Reset drives all outputs to 0 and the state to IDLE.
- Requesters:
  - A data request is `d_read | d_write`.
  - If both `d_read` and `d_write` are high, the access is a write and `d_read` is ignored.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - If a data request is present, go to BUSY_D. Latch `d_addr`/`d_wdata`/type onto the `mem_*` outputs.
  - Otherwise, if `i_req` is high, go to BUSY_I. Latch `i_addr` and set `mem_read`.
  - Otherwise, stay in IDLE.
- BUSY_x:
  - `mem_*` stays constant.
  - When `mem_ready` is sampled high:
    - Clear `mem_read`/`mem_write`.
    - Capture `mem_rdata` into the winner's rdata register. For data writes, `d_rdata` is unchanged.
    - Set the winner's ready bit and go to RESP.
- RESP:
  - The winner's ready is high for exactly this cycle. No grant is made this cycle, so a request still held during the ready cycle cannot be re-granted.
  - Next state is IDLE.
- Address and data inputs are sampled only at grant. Requester changes during BUSY are ignored.
- `mem_ready` outside BUSY_x is ignored.
- `i_rdata`/`d_rdata` hold their last captured value after ready drops.

## Timing
- Grant edge: request sampled in IDLE at edge N; `mem_read` or `mem_write` is high from cycle N+1.
- Memory latency: `mem_ready` sampled high at edge M; `mem_*` strobes low and x_ready high in cycle M+1; state is IDLE in cycle M+2.
- Minimum latency with zero-wait memory (`mem_ready` in the first strobe cycle): request at edge N, ready in cycle N+2, next grant possible at edge N+3.
- Throughput: one access per (memory latency + 2) cycles.
- Simultaneous requests: the loser stays pending with ready low and is granted on the next IDLE if still held.
- `rst` mid-access: immediate abort. Strobes drop asynchronously, no ready is issued, and the state returns to IDLE. The memory model shares `rst`.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A `last_d` flag records whether the most recent completed access was a data access. Reset value is 0.
  - When both requesters are pending in IDLE and `last_d` = 1, IF wins. Otherwise data wins.
  - A lone requester always wins.
- `MEM_ARB_RR_EN` undefined: fixed data priority and no `last_d` register. IF can starve under back-to-back data traffic.

## Structure
- Shared package `cpu_pkg`:
  - State enum `arb_state_t` (IDLE, BUSY_I, BUSY_D, RESP).
  - Requester ID constants `REQ_I` and `REQ_D`.
  - `ADDR_W`/`DATA_W` defaults.
- Single module with no sub-module. The grant decision is a small combinational block inside `mem_arbiter`.

## Test plan
- Reset, then `i_req`=1 with `i_addr`=0x10 and `mem_ready` returning after 3 cycles: `mem_read`=1 with `mem_addr`=0x10 for 3 cycles, then `i_ready` pulses once with `i_rdata`=0xDEADBEEF.
- `d_write`=1 with `d_addr`=0x20, `d_wdata`=0x12345678 and zero-wait memory: `mem_write` high for 1 cycle with the matching addr/data, then `d_ready` pulses; `i_ready` stays 0.
- `i_req` and `d_read` raised in the same cycle and both held (`MEM_ARB_RR_EN` undefined): data is served first, then fetch, with one `d_ready` and one `i_ready` pulse in that order.
- `MEM_ARB_RR_EN` defined, both requesters held continuously for 6 accesses: grants alternate D, I, D, I, D, I.
- `rst` asserted while in BUSY_D with `mem_write`=1: `mem_write` drops without waiting for a clock edge, `d_ready` is never pulsed, and after release an `i_req` is granted normally.
- Requester holds `i_req` through its `i_ready` pulse cycle and drops it the cycle after: exactly one memory access, with no duplicate grant.
